// File: rtl/down_counter_pkg.sv
// Shared state encodings and default width for the down_counter slice.
// Auto-reload is selected with the DOWN_COUNTER_RELOAD_EN macro (see down_counter.sv).
package down_counter_pkg;

   localparam int LEN_COUNTER_DATA = 16;
   localparam int LEN_DC_STATE     = 2;

   localparam logic [LEN_DC_STATE-1:0] DC_IDLE = 2'd0;
   localparam logic [LEN_DC_STATE-1:0] DC_RUN  = 2'd1;
   localparam logic [LEN_DC_STATE-1:0] DC_DONE = 2'd2;

endpackage

// File: rtl/down_counter_register.sv
// Loadable storage register with asynchronous active-low clear; q only changes when ld is high.
module down_counter_register #(
   parameter int WORD_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ld,
   input  logic [WORD_LENGTH-1:0] d,
   output logic [WORD_LENGTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end
   end

endmodule

// File: rtl/down_counter.sv
// Loadable countdown counter with start/done handshake and synchronous abort.
// Define DOWN_COUNTER_RELOAD_EN to build the auto-reload variant (reload_val register, no done).
module down_counter
   import down_counter_pkg::*;
#(
   parameter int WORD_LENGTH = LEN_COUNTER_DATA
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] load,
   input  logic                   en,
   input  logic                   stop,
   output logic [WORD_LENGTH-1:0] out,
   output logic                   busy,
   output logic                   done,
   output logic                   underflow
);

   logic [LEN_DC_STATE-1:0] state_q;
   logic [LEN_DC_STATE-1:0] state_d;
   logic [WORD_LENGTH-1:0]  cnt_d;
   logic                    cnt_ld;
   logic                    load_nz;

   assign load_nz = (load != '0);

`ifdef DOWN_COUNTER_RELOAD_EN
   logic [WORD_LENGTH-1:0] reload_val;
   logic                   rl_ld;
   logic                   uf_q;
   logic                   uf_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = out;
      cnt_ld  = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      rl_ld   = 1'b0;
      uf_d    = 1'b0;
`endif
      case (state_q)
         DC_RUN: begin
            if (en) begin
               cnt_ld = 1'b1;
               if (out > WORD_LENGTH'(1)) begin
                  cnt_d = out - WORD_LENGTH'(1);
               end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
                  cnt_d = reload_val;
                  uf_d  = 1'b1;
`else
                  cnt_d   = '0;
                  state_d = DC_DONE;
`endif
               end
            end
         end
         // IDLE and DONE both accept start; DONE otherwise falls back to IDLE
         default: begin
            if (state_q == DC_DONE) begin
               state_d = DC_IDLE;
            end
            if (start && load_nz) begin
               state_d = DC_RUN;
               cnt_d   = load;
               cnt_ld  = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
               rl_ld   = 1'b1;
`endif
            end
`ifndef DOWN_COUNTER_RELOAD_EN
            else if (start) begin
               state_d = DC_DONE;
            end
`endif
         end
      endcase
      // Abort wins over start and en, and never produces a completion pulse
      if (stop) begin
         state_d = DC_IDLE;
         cnt_d   = '0;
         cnt_ld  = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
         rl_ld   = 1'b0;
         uf_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DC_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   down_counter_register #(.WORD_LENGTH(WORD_LENGTH)) u_count (
      .clk (clk),
      .rst (rst),
      .ld  (cnt_ld),
      .d   (cnt_d),
      .q   (out)
   );

`ifdef DOWN_COUNTER_RELOAD_EN
   down_counter_register #(.WORD_LENGTH(WORD_LENGTH)) u_reload (
      .clk (clk),
      .rst (rst),
      .ld  (rl_ld),
      .d   (load),
      .q   (reload_val)
   );

   // Registered so the pulse coincides with the first cycle of the reloaded value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uf_q <= 1'b0;
      end else begin
         uf_q <= uf_d;
      end
   end

   assign busy      = (state_q == DC_RUN);
   assign done      = 1'b0;
   assign underflow = uf_q;
`else
   assign busy      = (state_q == DC_RUN);
   assign done      = (state_q == DC_DONE);
   assign underflow = done;
`endif

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: hand-computed out/busy/done/underflow after each edge.
module tb_down_counter;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] load;
   logic         en;
   logic         stop;
   logic [W-1:0] out;
   logic         busy;
   logic         done;
   logic         underflow;

   int vecs = 0;
   int errs = 0;

   down_counter #(.WORD_LENGTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .load      (load),
      .en        (en),
      .stop      (stop),
      .out       (out),
      .busy      (busy),
      .done      (done),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] e_out, input logic e_busy,
                      input logic e_done, input logic e_uf);
      logic [W+2:0] obs;
      logic [W+2:0] exp;
      obs = {out, busy, done, underflow};
      exp = {e_out, e_busy, e_done, e_uf};
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed out=%0d busy=%b done=%b uf=%b, expected out=%0d busy=%b done=%b uf=%b",
                tag, out, busy, done, underflow, e_out, e_busy, e_done, e_uf);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; load = '0; en = 1'b0; stop = 1'b0;
      #12;
      chk("reset", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;

`ifdef DOWN_COUNTER_RELOAD_EN
      // Auto-reload: 3,2,1,3,2,1 with underflow on each reappearance of 3
      start = 1'b1; load = 3; en = 1'b1;
      tick(); start = 1'b0;
      chk("rl_3a", 3, 1, 0, 0);
      tick(); chk("rl_2a", 2, 1, 0, 0);
      tick(); chk("rl_1a", 1, 1, 0, 0);
      tick(); chk("rl_3b", 3, 1, 0, 1);
      tick(); chk("rl_2b", 2, 1, 0, 0);
      tick(); chk("rl_1b", 1, 1, 0, 0);
      tick(); chk("rl_3c", 3, 1, 0, 1);
      stop = 1'b1;
      tick(); stop = 1'b0;
      chk("rl_stop", 0, 0, 0, 0);
      start = 1'b1; load = 0;
      tick(); start = 1'b0;
      chk("rl_zero_ign", 0, 0, 0, 0);
      tick(); chk("rl_zero_idle", 0, 0, 0, 0);
`else
      // Basic countdown from 5
      start = 1'b1; load = 5; en = 1'b1;
      tick(); start = 1'b0;
      chk("cnt_5", 5, 1, 0, 0);
      tick(); chk("cnt_4", 4, 1, 0, 0);
      tick(); chk("cnt_3", 3, 1, 0, 0);
      tick(); chk("cnt_2", 2, 1, 0, 0);
      tick(); chk("cnt_1", 1, 1, 0, 0);
      tick(); chk("cnt_done", 0, 0, 1, 1);
      tick(); chk("cnt_idle", 0, 0, 0, 0);

      // Two-cycle stall in a count of 3
      start = 1'b1; load = 3;
      tick(); start = 1'b0;
      chk("stl_3", 3, 1, 0, 0);
      tick(); chk("stl_2", 2, 1, 0, 0);
      en = 1'b0;
      tick(); chk("stl_hold1", 2, 1, 0, 0);
      tick(); chk("stl_hold2", 2, 1, 0, 0);
      en = 1'b1;
      tick(); chk("stl_1", 1, 1, 0, 0);
      tick(); chk("stl_done", 0, 0, 1, 1);

      // Zero load, then restart straight out of DONE
      tick(); chk("zl_idle", 0, 0, 0, 0);
      start = 1'b1; load = 0;
      tick();
      chk("zl_done", 0, 0, 1, 1);
      load = 2;
      tick(); start = 1'b0;
      chk("rs_2", 2, 1, 0, 0);
      tick(); chk("rs_1", 1, 1, 0, 0);
      tick(); chk("rs_done", 0, 0, 1, 1);
      tick(); chk("rs_idle", 0, 0, 0, 0);

      // stop beats start in the same cycle, no completion pulse
      start = 1'b1; load = 4;
      tick(); start = 1'b0;
      chk("ab_4", 4, 1, 0, 0);
      tick(); chk("ab_3", 3, 1, 0, 0);
      tick(); chk("ab_2", 2, 1, 0, 0);
      stop = 1'b1; start = 1'b1; load = 7;
      tick(); stop = 1'b0; start = 1'b0;
      chk("ab_stop", 0, 0, 0, 0);
      tick(); chk("ab_nodone", 0, 0, 0, 0);

      // start ignored while running, then asynchronous reset mid-count
      start = 1'b1; load = 3;
      tick();
      chk("ign_3", 3, 1, 0, 0);
      load = 9;
      tick(); start = 1'b0;
      chk("ign_2", 2, 1, 0, 0);
      #2 rst = 1'b0;
      #1 chk("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      tick(); chk("post_rst", 0, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable countdown counter with a start/done handshake, the decrementing counterpart of the modulo up-counter. The controller hands it a cycle budget and it counts the budget down to zero. It reports completion with a one-cycle `done`/`underflow` pulse and can be aborted at any time. It sits beside the existing counter in the datapath and drives loop-exit and timeout conditions into the control FSMs.

## Interface
- `WORD_LENGTH`, default `` `LEN_COUNTER_DATA ``, width of the count and load value.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low. Drives the block to IDLE with all outputs 0.
- `start`  in  1  request to load `load` and begin counting; sampled on the clock edge.
- `load`  in  WORD_LENGTH  initial count; sampled when `start` is accepted.
- `en`  in  1  count enable; decrement only when high in RUN.
- `stop`  in  1  synchronous abort to IDLE.
- `out`  out  WORD_LENGTH  current count.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on completion.
- `underflow`  out  1  one-cycle pulse when the count reaches zero.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `out`=0, `busy`=0.
  - `start` with `load`≠0 → RUN; `out`←`load`; `load` is also latched into `reload_val`.
  - `start` with `load`=0 → DONE; `out` stays 0.
- **RUN**
  - `busy`=1.
  - `en`=1 and `out`>1 → `out`←`out`−1.
  - `en`=1 and `out`=1 → `out`←0, state → DONE.
  - `en`=0 → hold.
  - `start` is ignored in RUN. It is never queued.
- **DONE**
  - Lasts exactly one cycle. `done`=1, `underflow`=1, `busy`=0, `out`=0.
  - Next state is IDLE.
  - `start` in DONE is accepted exactly as in IDLE: back-to-back restart with no gap.
- **stop**
  - In any state → IDLE next cycle, `out`←0.
  - No `done`/`underflow` pulse is produced by an abort.
  - `stop` has priority over `start` and `en` in the same cycle.
- **Arithmetic:** unsigned, WORD_LENGTH bits. The decrement never wraps below 0 because exit occurs at 1.
- **Output timing:** `done`, `underflow` and `busy` are state-decoded, with no combinational path from inputs.

## Timing
- **Reset values:** state IDLE; `out`, `busy`, `done`, `underflow` = 0; `reload_val`=0.
- **Count latency:** with `start` at edge 0, `load`=N≥1 and `en` held high:
  - `out`=N after edge 0, then N−1, …, 1 after edge N−1.
  - `done` high during the cycle after edge N, i.e. N+1 cycles after start.
- **Stalls:** each low-`en` cycle in RUN adds one cycle.
- **Zero load:** `load`=0 gives `done` one cycle after start.
- **Reset mid-operation:** immediate return to reset values, regardless of state.

## Configuration
- **Macro:** `DOWN_COUNTER_RELOAD_EN`.
- **Defined (auto-reload):**
  - In RUN with `en`=1 and `out`=1, `out`←`reload_val` and the block stays in RUN.
  - `underflow` pulses for the one cycle in which the reloaded value first appears.
  - `done` is never asserted; only `stop` or `rst` leaves RUN.
  - `start` with `load`=0 is ignored and the block stays in IDLE.
- **Undefined:**
  - Behaviour as in Operation.
  - The `reload_val` register is not instantiated.
  - `underflow` is identical to `done`.

## Structure
- **Shared include (`ISA.v`):**
  - State encodings `` `DC_IDLE ``, `` `DC_RUN ``, `` `DC_DONE ``, 2-bit.
  - Width macro `` `LEN_DC_STATE ``.
  - The existing `` `LEN_COUNTER_DATA `` supplies the default width.
- **Sub-module:** the count is held in the existing `Register` (parameterised WORD_LENGTH, `ld`=1 whenever `out` changes). `reload_val` uses a second `Register` instance.

## Test plan
- **Basic countdown:** reset, then `start`=1, `load`=5, `en`=1 → `out` 5,4,3,2,1. `done`=`underflow`=1 on the 6th cycle after start, then IDLE with `out`=0.
- **Stalls:** `load`=3 with `en` low for 2 cycles mid-count → `done` delayed to the 6th cycle. `out` holds its value during the stall.
- **Zero load and restart:**
  - `load`=0 → `done` pulse 1 cycle after start.
  - `start`=1, `load`=2 during DONE → RUN with `out`=2 next cycle.
- **Abort priority:** `stop` at `out`=2, with `start`=1 in the same cycle → IDLE, `out`=0, no `done`. Asynchronous `rst` low mid-RUN → all outputs 0 immediately.
- **Auto-reload** (`DOWN_COUNTER_RELOAD_EN` defined, `load`=3, `en`=1) → `out` 3,2,1,3,2,1. `underflow` pulses with each reappearance of 3. `done` stays 0. `busy` stays 1 until `stop`.
